// File: rtl/iiitb_fifo_pkg.sv
// Shared definitions for the iiitb_fifo read-side engine.
package iiitb_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_LEN_WIDTH  = 8;

    // Skid slots available to hold returned words (stored + in flight).
    localparam logic [2:0] SKID_DEPTH = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_FLUSH = 3'd4
    } rd_state_e;

endpackage

// File: rtl/iiitb_fifo_reader_if.sv
// Bundle of burst control, FIFO pop side and downstream stream signals.
interface iiitb_fifo_reader_if
    import iiitb_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
);
    logic                  start;
    logic [LEN_WIDTH-1:0]  burst_len;
    logic                  abort;
    logic                  buf_empty;
    logic [DATA_WIDTH-1:0] buf_out;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;
    logic [LEN_WIDTH-1:0]  words_out;

    // Reader side.
    modport master (
        input  start, burst_len, abort, buf_empty, buf_out, out_ready,
        output rd_en, out_data, out_valid, busy, done, words_out
    );

    // Environment side (controller, FIFO and consumer).
    modport slave (
        output start, burst_len, abort, buf_empty, buf_out, out_ready,
        input  rd_en, out_data, out_valid, busy, done, words_out
    );
endinterface

// File: rtl/iiitb_skid_buf.sv
// Two-entry valid/ready register slice; flush empties it in one cycle.
module iiitb_skid_buf
    import iiitb_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  out_pop,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            count
);
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            count_q, count_d;

    // Push/pop bookkeeping; the caller never pushes into a full slice.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({in_valid, out_pop})
                2'b10: begin
                    if (count_q == 2'd0) head_d = in_data;
                    else                 tail_d = in_data;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_d = in_data;
                    end else begin
                        head_d = tail_q;
                        tail_d = in_data;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign count     = count_q;
endmodule

// File: rtl/iiitb_fifo_reader.sv
// Burst read engine: pops words from iiitb_fifo and streams them downstream.
//
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_RUN   | issuing pops until issued == len
//   ST_DRAIN | all pops issued, waiting for the last word to leave
//   ST_DONE  | one-cycle completion pulse
//   ST_FLUSH | abort: drop skid contents and any returning word
module iiitb_fifo_reader
    import iiitb_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    iiitb_fifo_reader_if.master bus
);
    rd_state_e             state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic [LEN_WIDTH-1:0]  words_q, words_d;
    logic                  inflight_q, inflight_d;

    logic                  flush;
    logic                  rd_en;
    logic                  deq;
    logic [2:0]            occ;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic [1:0]            skid_count;

    assign flush = (state_q == ST_FLUSH);
    assign deq   = skid_valid & ~flush & bus.out_ready;
    // Slots committed once this cycle settles: stored + returning - leaving.
    assign occ   = {1'b0, skid_count} + {2'b00, inflight_q} - {2'b00, deq};
    assign rd_en = (state_q == ST_RUN) & ~bus.buf_empty & ~bus.abort &
                   (issued_q < len_q) & (occ < SKID_DEPTH);

    iiitb_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (inflight_q & ~flush),
        .in_data   (bus.buf_out),
        .out_pop   (deq),
        .out_valid (skid_valid),
        .out_data  (skid_data),
        .count     (skid_count)
    );

    // Next-state and counter updates.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q + {{(LEN_WIDTH-1){1'b0}}, rd_en};
        words_d    = words_q + {{(LEN_WIDTH-1){1'b0}}, deq};
        inflight_d = rd_en;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    len_d    = bus.burst_len;
                    issued_d = '0;
                    words_d  = '0;
                    state_d  = (bus.burst_len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (bus.abort)                state_d = ST_FLUSH;
                else if (issued_q == len_q)   state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Completion is judged on post-handshake values so done follows
                // the last delivered word directly.
                if (bus.abort)                                  state_d = ST_FLUSH;
                else if (occ == 3'd0 && words_d == len_q)       state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_FLUSH: if (!inflight_q) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            words_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            words_q    <= words_d;
            inflight_q <= inflight_d;
        end
    end

    assign bus.rd_en     = rd_en;
    assign bus.out_valid = skid_valid & ~flush;
    assign bus.out_data  = skid_data;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.words_out = words_q;
endmodule
